// File: rtl/multicycle_mem_arbiter_pkg.sv
// Shared constants for the two-port multicycle memory arbiter:
// controller state encoding, owner id and the request payload.
package multicycle_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ISSUE    = 2'd1,
        ST_WAIT_RSP = 2'd2,
        ST_RESPOND  = 2'd3
    } arb_state_e;

    typedef enum logic {
        OWNER_P0 = 1'b0,
        OWNER_P1 = 1'b1
    } owner_e;

    typedef struct packed {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
    } mem_req_t;

endpackage

// File: rtl/multicycle_mem_arbiter_grant.sv
// Combinational 2-way grant picker: round-robin on ties unless fixed
// priority is selected, in which case port 0 wins every tie.
module mem_arb_grant
    import multicycle_mem_arbiter_pkg::*;
(
    input  logic   req0,
    input  logic   req1,
    input  owner_e last_grant,
    input  logic   fixed_priority,
    output logic   grant_valid,
    output owner_e grant_id
);

    always_comb begin
        grant_valid = req0 | req1;
        grant_id    = OWNER_P0;
        if (req0 && req1) begin
            if (!fixed_priority && (last_grant == OWNER_P0)) begin
                grant_id = OWNER_P1;
            end
        end else if (req1) begin
            grant_id = OWNER_P1;
        end
    end

endmodule

// File: rtl/multicycle_mem_arbiter.sv
// Two requesters share one memory port; one transaction in flight at a time.
// Handshake: a request transfers in the cycle where pN_req_valid and pN_req_ready are both 1.
module multicycle_mem_arbiter
    import multicycle_mem_arbiter_pkg::*;
#(
    parameter int FIXED_PRIORITY = 0
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        p0_req_valid,
    output logic        p0_req_ready,
    input  logic        p0_req_write,
    input  logic [31:0] p0_req_addr,
    input  logic [31:0] p0_req_wdata,
    input  logic [3:0]  p0_req_wmask,
    output logic        p0_rsp_valid,
    output logic [31:0] p0_rsp_rdata,
    input  logic        p1_req_valid,
    output logic        p1_req_ready,
    input  logic        p1_req_write,
    input  logic [31:0] p1_req_addr,
    input  logic [31:0] p1_req_wdata,
    input  logic [3:0]  p1_req_wmask,
    output logic        p1_rsp_valid,
    output logic [31:0] p1_rsp_rdata,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rdata,
    output arb_state_e  dbg_state
);

    arb_state_e  state;
    arb_state_e  next_state;
    owner_e      last_grant;
    owner_e      owner;
    mem_req_t    req_q;
    logic [31:0] p0_rdata_q;
    logic [31:0] p1_rdata_q;
    logic        grant_valid;
    owner_e      grant_id;
    logic        take_grant;
    logic        take_rsp;
    mem_req_t    p0_req;
    mem_req_t    p1_req;
    logic [31:0] rsp_word;

    assign p0_req = '{write: p0_req_write, addr: p0_req_addr, wdata: p0_req_wdata, wmask: p0_req_wmask};
    assign p1_req = '{write: p1_req_write, addr: p1_req_addr, wdata: p1_req_wdata, wmask: p1_req_wmask};

    mem_arb_grant u_grant (
        .req0           (p0_req_valid),
        .req1           (p1_req_valid),
        .last_grant     (last_grant),
        .fixed_priority (FIXED_PRIORITY != 0),
        .grant_valid    (grant_valid),
        .grant_id       (grant_id)
    );

    assign take_grant = (state == ST_IDLE) && grant_valid;
    assign take_rsp   = (state == ST_WAIT_RSP) && mem_rsp_valid;
    assign rsp_word   = req_q.write ? 32'd0 : mem_rdata;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state    = state;
        p0_req_ready  = 1'b0;
        p1_req_ready  = 1'b0;
        mem_req_valid = 1'b0;
        p0_rsp_valid  = 1'b0;
        p1_rsp_valid  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (grant_valid) begin
                    p0_req_ready = (grant_id == OWNER_P0);
                    p1_req_ready = (grant_id == OWNER_P1);
                    next_state   = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    next_state = ST_WAIT_RSP;
                end
            end
            ST_WAIT_RSP: begin
                if (mem_rsp_valid) begin
                    next_state = ST_RESPOND;
                end
            end
            ST_RESPOND: begin
                p0_rsp_valid = (owner == OWNER_P0);
                p1_rsp_valid = (owner == OWNER_P1);
                next_state   = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // last_grant starts at port 1 so that port 0 wins the first tie.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            last_grant <= OWNER_P1;
            owner      <= OWNER_P0;
            req_q      <= '0;
            p0_rdata_q <= 32'd0;
            p1_rdata_q <= 32'd0;
        end else begin
            if (take_grant) begin
                last_grant <= grant_id;
                owner      <= grant_id;
                req_q      <= (grant_id == OWNER_P1) ? p1_req : p0_req;
            end
            if (take_rsp) begin
                if (owner == OWNER_P0) begin
                    p0_rdata_q <= rsp_word;
                end else begin
                    p1_rdata_q <= rsp_word;
                end
            end
        end
    end

    assign mem_write    = req_q.write;
    assign mem_addr     = req_q.addr;
    assign mem_wdata    = req_q.wdata;
    assign mem_wmask    = req_q.wmask;
    assign p0_rsp_rdata = p0_rdata_q;
    assign p1_rsp_rdata = p1_rdata_q;
    assign dbg_state    = state;

endmodule

// File: tb/tb_multicycle_mem_arbiter.sv
// Bench for the arbiter: a round-robin and a fixed-priority instance share
// the requester stimulus; each has its own memory responder and reference model.
module tb_multicycle_mem_arbiter;
    import multicycle_mem_arbiter_pkg::*;

    localparam int PH_NONE  = 0;
    localparam int PH_OFFER = 1;
    localparam int PH_WAIT  = 2;
    localparam int PH_DONE  = 3;
    localparam logic [31:0] JUNK = 32'h0BAD_F00D;

    // ---------------- clock / reset ----------------
    logic clock;
    logic reset_n;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // ---------------- shared requester inputs ----------------
    logic        p0_req_valid, p0_req_write;
    logic [31:0] p0_req_addr, p0_req_wdata;
    logic [3:0]  p0_req_wmask;
    logic        p1_req_valid, p1_req_write;
    logic [31:0] p1_req_addr, p1_req_wdata;
    logic [3:0]  p1_req_wmask;

    // ---------------- per-instance signals ----------------
    logic        p0_req_ready [2];
    logic        p1_req_ready [2];
    logic        p0_rsp_valid [2];
    logic        p1_rsp_valid [2];
    logic [31:0] p0_rsp_rdata [2];
    logic [31:0] p1_rsp_rdata [2];
    logic        mem_req_valid [2];
    logic        mem_req_ready [2];
    logic        mem_write [2];
    logic [31:0] mem_addr [2];
    logic [31:0] mem_wdata [2];
    logic [3:0]  mem_wmask [2];
    logic        mem_rsp_valid [2];
    logic [31:0] mem_rdata [2];
    arb_state_e  dbg_state [2];

    multicycle_mem_arbiter #(.FIXED_PRIORITY(0)) dut_rr (
        .clock(clock), .reset_n(reset_n),
        .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready[0]), .p0_req_write(p0_req_write),
        .p0_req_addr(p0_req_addr), .p0_req_wdata(p0_req_wdata), .p0_req_wmask(p0_req_wmask),
        .p0_rsp_valid(p0_rsp_valid[0]), .p0_rsp_rdata(p0_rsp_rdata[0]),
        .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready[0]), .p1_req_write(p1_req_write),
        .p1_req_addr(p1_req_addr), .p1_req_wdata(p1_req_wdata), .p1_req_wmask(p1_req_wmask),
        .p1_rsp_valid(p1_rsp_valid[0]), .p1_rsp_rdata(p1_rsp_rdata[0]),
        .mem_req_valid(mem_req_valid[0]), .mem_req_ready(mem_req_ready[0]),
        .mem_write(mem_write[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]), .mem_wmask(mem_wmask[0]),
        .mem_rsp_valid(mem_rsp_valid[0]), .mem_rdata(mem_rdata[0]), .dbg_state(dbg_state[0])
    );

    multicycle_mem_arbiter #(.FIXED_PRIORITY(1)) dut_fx (
        .clock(clock), .reset_n(reset_n),
        .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready[1]), .p0_req_write(p0_req_write),
        .p0_req_addr(p0_req_addr), .p0_req_wdata(p0_req_wdata), .p0_req_wmask(p0_req_wmask),
        .p0_rsp_valid(p0_rsp_valid[1]), .p0_rsp_rdata(p0_rsp_rdata[1]),
        .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready[1]), .p1_req_write(p1_req_write),
        .p1_req_addr(p1_req_addr), .p1_req_wdata(p1_req_wdata), .p1_req_wmask(p1_req_wmask),
        .p1_rsp_valid(p1_rsp_valid[1]), .p1_rsp_rdata(p1_rsp_rdata[1]),
        .mem_req_valid(mem_req_valid[1]), .mem_req_ready(mem_req_ready[1]),
        .mem_write(mem_write[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]), .mem_wmask(mem_wmask[1]),
        .mem_rsp_valid(mem_rsp_valid[1]), .mem_rdata(mem_rdata[1]), .dbg_state(dbg_state[1])
    );

    // ---------------- scoreboard bookkeeping ----------------
    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    logic [31:0] exp_q[$];

    int          grant_log [2][32];
    int          grant_n [2];
    int          grant_cyc [2];
    int          rsp_n [2];
    int          rsp_cyc [2];
    int          rsp_port [2];
    logic [31:0] rsp_data [2];
    int          offer_n [2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] rdata_for(input logic [31:0] addr);
        if (addr == 32'h100) return 32'hDEAD_BEEF;
        return {addr[15:0], 16'hC0DE};
    endfunction

    // ---------------- memory responder (one per instance) ----------------
    int ready_wait = 0;
    int rsp_delay  = 1;
    bit force_rsp  = 1'b0;
    int          wcnt [2];
    int          dcnt [2];
    logic [31:0] pend_data [2];

    initial begin : memory
        for (int i = 0; i < 2; i++) begin
            mem_req_ready[i] = 1'b0;
            mem_rsp_valid[i] = 1'b0;
            mem_rdata[i]     = JUNK;
            wcnt[i] = 0;
            dcnt[i] = 0;
            pend_data[i] = 32'd0;
        end
        forever begin
            @(posedge clock);
            #1;
            for (int i = 0; i < 2; i++) begin
                if (!reset_n) begin
                    mem_req_ready[i] = 1'b0;
                    mem_rsp_valid[i] = 1'b0;
                    mem_rdata[i]     = JUNK;
                    wcnt[i] = 0;
                    dcnt[i] = 0;
                    continue;
                end
                mem_rsp_valid[i] = force_rsp;
                mem_rdata[i]     = JUNK;
                if (mem_req_ready[i]) begin
                    mem_req_ready[i] = 1'b0;
                    dcnt[i] = rsp_delay;
                    wcnt[i] = 0;
                end else if (mem_req_valid[i]) begin
                    if (wcnt[i] < ready_wait) begin
                        wcnt[i]++;
                    end else begin
                        mem_req_ready[i] = 1'b1;
                        pend_data[i] = mem_write[i] ? 32'hFFFF_FFFF : rdata_for(mem_addr[i]);
                    end
                end
                if (dcnt[i] > 0) begin
                    dcnt[i]--;
                    if (dcnt[i] == 0) begin
                        mem_rsp_valid[i] = 1'b1;
                        mem_rdata[i]     = pend_data[i];
                    end
                end
            end
        end
    end

    // ---------------- reference model + per-cycle compare ----------------
    int          phase [2];
    int          lastg [2];
    int          own [2];
    mem_req_t    pay [2];
    logic [31:0] due [2];
    logic [31:0] exp_rd [2][2];

    initial begin : compare
        int win;
        for (int i = 0; i < 2; i++) begin
            phase[i] = PH_NONE;
            lastg[i] = 1;
            own[i]   = 0;
            exp_rd[i][0] = 32'd0;
            exp_rd[i][1] = 32'd0;
            grant_n[i] = 0; rsp_n[i] = 0; offer_n[i] = 0;
        end
        forever begin
            @(negedge clock);
            cyc++;
            for (int i = 0; i < 2; i++) begin
                if (!reset_n) begin
                    chk($sformatf("rst_p0_req_ready[%0d]", i), p0_req_ready[i], 0);
                    chk($sformatf("rst_p1_req_ready[%0d]", i), p1_req_ready[i], 0);
                    chk($sformatf("rst_p0_rsp_valid[%0d]", i), p0_rsp_valid[i], 0);
                    chk($sformatf("rst_p1_rsp_valid[%0d]", i), p1_rsp_valid[i], 0);
                    chk($sformatf("rst_mem_req_valid[%0d]", i), mem_req_valid[i], 0);
                    chk($sformatf("rst_mem_addr[%0d]", i), mem_addr[i], 0);
                    chk($sformatf("rst_mem_wdata[%0d]", i), mem_wdata[i], 0);
                    chk($sformatf("rst_p0_rsp_rdata[%0d]", i), p0_rsp_rdata[i], 0);
                    chk($sformatf("rst_p1_rsp_rdata[%0d]", i), p1_rsp_rdata[i], 0);
                    phase[i] = PH_NONE;
                    lastg[i] = 1;
                    exp_rd[i][0] = 32'd0;
                    exp_rd[i][1] = 32'd0;
                    continue;
                end
                // who must be granted this cycle, from the arbitration rules
                win = -1;
                if (phase[i] == PH_NONE && (p0_req_valid || p1_req_valid)) begin
                    if (p0_req_valid && p1_req_valid)
                        win = (i == 1) ? 0 : ((lastg[i] == 0) ? 1 : 0);
                    else
                        win = p0_req_valid ? 0 : 1;
                end
                chk($sformatf("p0_req_ready[%0d]", i), p0_req_ready[i], win == 0);
                chk($sformatf("p1_req_ready[%0d]", i), p1_req_ready[i], win == 1);
                chk($sformatf("mem_req_valid[%0d]", i), mem_req_valid[i], phase[i] == PH_OFFER);
                if (phase[i] == PH_OFFER) begin
                    offer_n[i]++;
                    chk($sformatf("mem_write[%0d]", i), mem_write[i], pay[i].write);
                    chk($sformatf("mem_addr[%0d]", i), mem_addr[i], pay[i].addr);
                    chk($sformatf("mem_wdata[%0d]", i), mem_wdata[i], pay[i].wdata);
                    chk($sformatf("mem_wmask[%0d]", i), mem_wmask[i], pay[i].wmask);
                end
                if (phase[i] == PH_DONE) exp_rd[i][own[i]] = due[i];
                chk($sformatf("p0_rsp_valid[%0d]", i), p0_rsp_valid[i], phase[i] == PH_DONE && own[i] == 0);
                chk($sformatf("p1_rsp_valid[%0d]", i), p1_rsp_valid[i], phase[i] == PH_DONE && own[i] == 1);
                chk($sformatf("p0_rsp_rdata[%0d]", i), p0_rsp_rdata[i], exp_rd[i][0]);
                chk($sformatf("p1_rsp_rdata[%0d]", i), p1_rsp_rdata[i], exp_rd[i][1]);

                // observed-event log for the directed literal checks
                if (p0_req_ready[i] || p1_req_ready[i]) begin
                    if (grant_n[i] < 32) grant_log[i][grant_n[i]] = p1_req_ready[i] ? 1 : 0;
                    grant_n[i]++;
                    grant_cyc[i] = cyc;
                end
                if (p0_rsp_valid[i] || p1_rsp_valid[i]) begin
                    rsp_n[i]++;
                    rsp_cyc[i]  = cyc;
                    rsp_port[i] = p1_rsp_valid[i] ? 1 : 0;
                    rsp_data[i] = p1_rsp_valid[i] ? p1_rsp_rdata[i] : p0_rsp_rdata[i];
                end

                case (phase[i])
                    PH_NONE: begin
                        if (win >= 0) begin
                            phase[i] = PH_OFFER;
                            own[i]   = win;
                            lastg[i] = win;
                            pay[i] = (win == 1)
                                ? '{write: p1_req_write, addr: p1_req_addr, wdata: p1_req_wdata, wmask: p1_req_wmask}
                                : '{write: p0_req_write, addr: p0_req_addr, wdata: p0_req_wdata, wmask: p0_req_wmask};
                        end
                    end
                    PH_OFFER: if (mem_req_ready[i]) phase[i] = PH_WAIT;
                    PH_WAIT: begin
                        if (mem_rsp_valid[i]) begin
                            due[i]   = pay[i].write ? 32'd0 : mem_rdata[i];
                            phase[i] = PH_DONE;
                        end
                    end
                    default: phase[i] = PH_NONE;
                endcase
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic clear_logs();
        for (int i = 0; i < 2; i++) begin
            grant_n[i] = 0; rsp_n[i] = 0; offer_n[i] = 0;
            grant_cyc[i] = 0; rsp_cyc[i] = 0; rsp_port[i] = -1; rsp_data[i] = 32'd0;
        end
    endtask

    task automatic do_req(input int port, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] wmask);
        bit got;
        got = 1'b0;
        @(posedge clock);
        #1;
        if (port == 0) begin
            p0_req_valid = 1'b1; p0_req_write = wr; p0_req_addr = addr;
            p0_req_wdata = wdata; p0_req_wmask = wmask;
        end else begin
            p1_req_valid = 1'b1; p1_req_write = wr; p1_req_addr = addr;
            p1_req_wdata = wdata; p1_req_wmask = wmask;
        end
        for (int k = 0; k < 50 && !got; k++) begin
            @(negedge clock);
            if (p0_req_ready[0] || p1_req_ready[0]) got = 1'b1;
        end
        chk("req_accepted_within_budget", got, 1);
        @(posedge clock);
        #1;
        p0_req_valid = 1'b0;
        p1_req_valid = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin : main
        reset_n = 1'b0;
        p0_req_valid = 1'b0; p0_req_write = 1'b0; p0_req_addr = 32'd0; p0_req_wdata = 32'd0; p0_req_wmask = 4'd0;
        p1_req_valid = 1'b0; p1_req_write = 1'b0; p1_req_addr = 32'd0; p1_req_wdata = 32'd0; p1_req_wmask = 4'd0;
        idle_cycles(3);
        reset_n = 1'b1;
        idle_cycles(2);
        chk("post_reset_state", 32'(dbg_state[0]), 32'(ST_IDLE));

        // single load on p0; p1 pulses valid while busy and must not be granted
        clear_logs();
        do_req(0, 1'b0, 32'h100, 32'h0, 4'hF);
        p1_req_valid = 1'b1;
        idle_cycles(1);
        p1_req_valid = 1'b0;
        idle_cycles(8);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("load_rsp_count[%0d]", i), rsp_n[i], 1);
            chk($sformatf("load_rsp_port[%0d]", i), rsp_port[i], 0);
            chk($sformatf("load_rsp_data[%0d]", i), rsp_data[i], 32'hDEAD_BEEF);
            chk($sformatf("load_latency[%0d]", i), rsp_cyc[i] - grant_cyc[i], 3);
            chk($sformatf("dropped_req_no_grant[%0d]", i), grant_n[i], 1);
        end

        // p1 store with memory stalling ready for 4 cycles
        clear_logs();
        ready_wait = 4;
        do_req(1, 1'b1, 32'h40, 32'h1234_5678, 4'hF);
        idle_cycles(14);
        ready_wait = 0;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("store_issue_cycles[%0d]", i), offer_n[i], 5);
            chk($sformatf("store_rsp_port[%0d]", i), rsp_port[i], 1);
            chk($sformatf("store_rsp_rdata[%0d]", i), rsp_data[i], 32'd0);
        end

        // both ports requesting continuously
        clear_logs();
        p0_req_write = 1'b0; p0_req_addr = 32'h200; p0_req_wdata = 32'hA0A0_A0A0; p0_req_wmask = 4'h3;
        p1_req_write = 1'b0; p1_req_addr = 32'h300; p1_req_wdata = 32'hB1B1_B1B1; p1_req_wmask = 4'hC;
        p0_req_valid = 1'b1;
        p1_req_valid = 1'b1;
        idle_cycles(18);
        p0_req_valid = 1'b0;
        p1_req_valid = 1'b0;
        idle_cycles(8);
        exp_q = '{32'd0, 32'd1, 32'd0, 32'd1};
        chk("rr_grant_count_min", grant_n[0] >= 4, 1);
        for (int k = 0; k < 4; k++) chk($sformatf("rr_grant_seq_%0d", k), grant_log[0][k], exp_q[k]);
        for (int k = 1; k < grant_n[0] && k < 32; k++)
            chk($sformatf("rr_no_repeat_%0d", k), grant_log[0][k] != grant_log[0][k-1], 1);
        chk("fx_grant_count_min", grant_n[1] >= 4, 1);
        for (int k = 0; k < grant_n[1] && k < 32; k++)
            chk($sformatf("fx_grant_p0_%0d", k), grant_log[1][k], 0);

        // spurious memory response while idle, then reset during WAIT_RSP
        clear_logs();
        force_rsp = 1'b1;
        idle_cycles(2);
        force_rsp = 1'b0;
        idle_cycles(2);
        rsp_delay = 6;
        do_req(0, 1'b0, 32'h104, 32'h0, 4'hF);
        idle_cycles(2);
        chk("mid_txn_state_wait_rsp", 32'(dbg_state[0]), 32'(ST_WAIT_RSP));
        reset_n = 1'b0;
        idle_cycles(2);
        reset_n = 1'b1;
        rsp_delay = 1;
        idle_cycles(8);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("abandoned_no_rsp[%0d]", i), rsp_n[i], 0);
            chk($sformatf("after_reset_idle[%0d]", i), 32'(dbg_state[i]), 32'(ST_IDLE));
            chk($sformatf("after_reset_rdata[%0d]", i), p0_rsp_rdata[i], 32'd0);
        end
        clear_logs();
        do_req(1, 1'b0, 32'h108, 32'h0, 4'hF);
        idle_cycles(8);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("recovery_rsp_count[%0d]", i), rsp_n[i], 1);
            chk($sformatf("recovery_rsp_port[%0d]", i), rsp_port[i], 1);
            chk($sformatf("recovery_rsp_data[%0d]", i), rsp_data[i], 32'h0108_C0DE);
            chk($sformatf("recovery_latency[%0d]", i), rsp_cyc[i] - grant_cyc[i], 3);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
